pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 16, giving the operand and result width in bits (legal values 2 or more).
REQ-002 The block SHALL have parameter SHAMTWIDTH, default 5, giving the width of the shift-amount input.
REQ-003 Port Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port Rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port start  input  1  SHALL be the request strobe, sampled on each rising Clk edge.
REQ-006 Port a  input  DATAWIDTH  SHALL be the operand.
REQ-007 Port sh_amt  input  SHAMTWIDTH  SHALL be the unsigned shift amount.
REQ-008 Port mode  input  2  SHALL select the operation: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
REQ-009 Port d  output  DATAWIDTH  SHALL be the registered result.
REQ-010 Port busy  output  1  SHALL be high while an operation is in progress.
REQ-011 Port done  output  1  SHALL be a one-cycle pulse marking a new valid d.

Function
REQ-012 The block SHALL use two states, IDLE and BUSY, and SHALL shift an internal working register by exactly 1 bit per BUSY cycle.
REQ-013 On a Clk edge in IDLE with start=1, the block SHALL capture a, the mode and the effective count into internal registers and enter BUSY.
REQ-014 The effective count SHALL be min(sh_amt, DATAWIDTH) for modes 00, 01 and 10, and sh_amt mod DATAWIDTH for mode 11; the counter SHALL be wide enough to hold DATAWIDTH.
REQ-015 On each BUSY edge with count not equal to 0, the block SHALL shift the working register by one position and decrement count by 1.
REQ-016 The single-bit shift rules SHALL be: mode 00 fills the MSB with 0; mode 01 replicates the captured sign bit; mode 10 fills the LSB with 0; mode 11 moves the LSB to the MSB.
REQ-017 On a BUSY edge with count=0, the block SHALL load d from the working register, drive done=1 for exactly one cycle, and return to IDLE.
REQ-018 Latency SHALL be effective count + 1 edges from the start-sampling edge to the edge that raises done; an effective count of 0 gives d=a after 1 edge.
REQ-019 busy SHALL be 1 exactly while in BUSY, and done and busy SHALL never be 1 in the same cycle.
REQ-020 start SHALL be ignored while in BUSY, with no effect on the captured operands or the count.
REQ-021 The block SHALL accept start on the edge immediately after the done pulse (back-to-back operation).
REQ-022 d SHALL hold its value between done pulses, and changes to a, sh_amt or mode after capture SHALL NOT affect the result in progress.

Reset
REQ-023 Asserting Rst SHALL immediately, without waiting for a Clk edge, force state to IDLE, d=0, busy=0, done=0, and clear the count and working register.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse; start is ignored while Rst=1.
REQ-025 After Rst deasserts, the first start SHALL be accepted on the next rising Clk edge.

Verification (DATAWIDTH=16, SHAMTWIDTH=5)
REQ-026 Logical and arithmetic right: a=0x8000, sh_amt=3, mode=00 -> d=0x1000 and done on the 4th edge after start; repeat with mode=01 -> d=0xF000.
REQ-027 Left and rotate: a=0x0001, sh_amt=15, mode=10 -> d=0x8000 after 16 edges; a=0x0001, sh_amt=17, mode=11 -> d=0x8000 after 2 edges.
REQ-028 Saturation and zero amount: a=0xFFFF, sh_amt=20, mode=00 -> d=0x0000 after 17 edges; a=0x1234, sh_amt=0 -> d=0x1234, done on the 1st edge with busy never high.
REQ-029 Ignored start: a second start pulse while busy=1 -> first result unchanged and exactly one done pulse; a start on the edge after done -> accepted.
REQ-030 Reset mid-operation: Rst asserted between edges during a 10-cycle shift -> d=0, busy=0, done=0 immediately, no later done pulse; a new op after release -> correct result.

Source files
------------

// File: rtl/pipe_shifter_if.sv
// pipe_shifter_if: request/result bundle for the serial shifter
interface pipe_shifter_if #(
  parameter int DATAWIDTH  = 16,
  parameter int SHAMTWIDTH = 5
);
  logic                  start;
  logic [DATAWIDTH-1:0]  a;
  logic [SHAMTWIDTH-1:0] sh_amt;
  logic [1:0]            mode;
  logic [DATAWIDTH-1:0]  d;
  logic                  busy;
  logic                  done;
  modport master (output start, a, sh_amt, mode, input d, busy, done);
  modport slave  (input start, a, sh_amt, mode, output d, busy, done);
endinterface

// File: rtl/pipe_shifter.sv
// pipe_shifter: one-bit-per-cycle shifter (logical/arith right, logical left, rotate right)
module pipe_shifter #(
  parameter int DATAWIDTH  = 16,
  parameter int SHAMTWIDTH = 5
) (
  input logic           Clk,
  input logic           Rst,
  pipe_shifter_if.slave bus
);
  localparam int CW = $clog2(DATAWIDTH + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                state, state_n;
  logic [DATAWIDTH-1:0]  work, work_sh;
  logic [CW-1:0]         cnt, cnt_eff;
  logic [1:0]            md;
  logic [SHAMTWIDTH-1:0] sh;
  logic [31:0]           amt;
  logic                  pend, accept;
  assign sh       = bus.sh_amt;
  assign bus.busy = state == BUSY;
  always_comb begin
    amt     = 32'(sh);
    cnt_eff = bus.mode == 2'b11 ? CW'(amt % 32'(DATAWIDTH))
                                : CW'(amt >= 32'(DATAWIDTH) ? 32'(DATAWIDTH) : amt);
    accept  = state == IDLE && bus.start && !pend;
    work_sh = md == 2'b00 ? {1'b0, work[DATAWIDTH-1:1]} :
              md == 2'b01 ? {work[DATAWIDTH-1], work[DATAWIDTH-1:1]} :
              md == 2'b10 ? {work[DATAWIDTH-2:0], 1'b0} :
                            {work[0], work[DATAWIDTH-1:1]};
    state_n = state == IDLE ? (accept && cnt_eff != '0 ? BUSY : IDLE)
                            : (cnt == '0 ? IDLE : BUSY);
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= IDLE;
    else     state <= state_n;
  // A zero-count request never enters BUSY; pend delivers its result one edge later
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      work     <= '0;
      cnt      <= '0;
      md       <= '0;
      pend     <= 1'b0;
      bus.d    <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      pend     <= 1'b0;
      if (accept) begin
        work <= bus.a;
        md   <= bus.mode;
        cnt  <= cnt_eff;
        pend <= cnt_eff == '0;
      end else if (pend || (state == BUSY && cnt == '0)) begin
        bus.d    <= work;
        bus.done <= 1'b1;
      end else if (state == BUSY) begin
        work <= work_sh;
        cnt  <= cnt - CW'(1);
      end
    end
endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: directed vectors with a done-driven scoreboard for pipe_shifter
module tb_pipe_shifter;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;
  pipe_shifter_if #(.DATAWIDTH(16), .SHAMTWIDTH(5)) bus();
  pipe_shifter #(.DATAWIDTH(16), .SHAMTWIDTH(5)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  typedef struct {logic [15:0] d; int cyc;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc++;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge Clk)
    if (bus.done) begin
      chk("done_busy_overlap", 32'(bus.busy), 0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got d=%0h expected no done", bus.d);
      end else begin
        mon_e = q.pop_front();
        chk("d", 32'(bus.d), 32'(mon_e.d));
        chk("latency_edge", cyc, mon_e.cyc);
      end
    end
  task automatic issue(logic [15:0] a, logic [4:0] s, logic [1:0] m, logic [15:0] ed, int lat, bit push);
    bus.a      = a;
    bus.sh_amt = s;
    bus.mode   = m;
    bus.start  = 1'b1;
    if (push) q.push_back('{ed, cyc + 1 + lat});
    @(negedge Clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      seen = bus.done;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
  initial begin
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.sh_amt = '0;
    bus.mode   = '0;
    repeat (2) @(negedge Clk);
    chk("reset_d", 32'(bus.d), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    Rst = 1'b0;
    issue(16'h8000, 5'd3, 2'b00, 16'h1000, 4, 1);
    wait_done("lsr");
    repeat (3) @(negedge Clk);
    chk("d_hold", 32'(bus.d), 32'h1000);
    issue(16'h8000, 5'd3, 2'b01, 16'hF000, 4, 1);
    wait_done("asr");
    issue(16'h0001, 5'd15, 2'b10, 16'h8000, 16, 1);
    wait_done("lsl");
    issue(16'h0001, 5'd17, 2'b11, 16'h8000, 2, 1);
    wait_done("ror_mod");
    issue(16'hFFFF, 5'd20, 2'b00, 16'h0000, 17, 1);
    wait_done("lsr_sat");
    issue(16'h1234, 5'd0, 2'b00, 16'h1234, 1, 1);
    chk("zero_busy", 32'(bus.busy), 0);
    wait_done("zero");
    chk("zero_busy_at_done", 32'(bus.busy), 0);
    @(negedge Clk);
    issue(16'h00F0, 5'd4, 2'b10, 16'h0F00, 5, 1);
    @(negedge Clk);
    bus.a      = 16'hFFFF;
    bus.sh_amt = 5'd1;
    bus.mode   = 2'b00;
    bus.start  = 1'b1;
    @(negedge Clk);
    bus.start  = 1'b0;
    bus.a      = 16'h5555;
    bus.mode   = 2'b11;
    wait_done("ignored_start");
    issue(16'hA5A5, 5'd4, 2'b11, 16'h5A5A, 5, 1);
    wait_done("back_to_back");
    repeat (4) @(negedge Clk);
    chk("d_hold2", 32'(bus.d), 32'h5A5A);
    issue(16'h4000, 5'd10, 2'b00, 16'h0000, 11, 0);
    repeat (3) @(negedge Clk);
    chk("mid_busy", 32'(bus.busy), 1);
    Rst = 1'b1;
    #1;
    chk("abort_d", 32'(bus.d), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    bus.start = 1'b1;
    repeat (3) @(negedge Clk);
    bus.start = 1'b0;
    chk("rst_start_ignored", 32'(bus.busy), 0);
    Rst = 1'b0;
    repeat (12) @(negedge Clk);
    chk("no_late_done_d", 32'(bus.d), 0);
    issue(16'h4000, 5'd2, 2'b01, 16'h1000, 3, 1);
    wait_done("after_reset");
    repeat (3) @(negedge Clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
